// File: rtl/figure_selector.sv
// figure_selector: turns raw next/previous push-buttons into a one-hot
// figure select for the text overlay. Each button is synchronised and
// debounced, and each press becomes one step through the nine figures.
// The step is applied only on frame_start so the caption changes between
// frames and never part-way through one.
module figure_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       frame_start,
    output logic [3:0] fig_index,
    output logic       circle_select,
    output logic       square_select,
    output logic       triangle_select,
    output logic       oval_select,
    output logic       rectangle_select,
    output logic       diamond_select,
    output logic       hexagon_select,
    output logic       pentagon_select,
    output logic       star_select
);

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_NEXT = 2'd1,
        REQ_PREV = 2'd2
    } req_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       LAST_FIG = 4'd8;

    // Bit 0 carries the "next" button, bit 1 the "previous" button.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [1:0]       edge_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;

    req_e             pend_q;
    req_e             pulse_req;
    req_e             eff_req;
    logic [3:0]       fig_q;
    logic [3:0]       fig_d;
    logic [8:0]       sel_q;

    assign btn_raw = {btn_prev, btn_next};

    // A press is the cycle where the debounced level is high but its
    // one-cycle-delayed copy is still low; releases produce nothing.
    assign press = deb_q & ~edge_q;

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count mismatched cycles, accept the synced level
    // once it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '{default: '0};
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels, their delayed copies for edge detection, counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q    <= '0;
            edge_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            deb_q    <= deb_d;
            edge_q   <= deb_q;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // Translate this cycle's press pulses into a request; both at once cancel.
    always_comb begin
        unique case (press)
            2'b01:   pulse_req = REQ_NEXT;
            2'b10:   pulse_req = REQ_PREV;
            default: pulse_req = REQ_NONE;
        endcase
    end

    // Next figure index: a same-cycle pulse takes priority over the pending request.
    always_comb begin
        eff_req = (press != 2'b00) ? pulse_req : pend_q;
        fig_d   = fig_q;
        if (frame_start) begin
            unique case (eff_req)
                REQ_NEXT: fig_d = (fig_q == LAST_FIG) ? 4'd0 : fig_q + 4'd1;
                REQ_PREV: fig_d = (fig_q == 4'd0) ? LAST_FIG : fig_q - 4'd1;
                default:  fig_d = fig_q;
            endcase
        end
    end

    // Pending-request state, figure index and registered one-hot selects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= REQ_NONE;
            fig_q  <= '0;
            sel_q  <= 9'd1;
        end else begin
            if (frame_start) begin
                pend_q <= REQ_NONE;
            end else if (press != 2'b00) begin
                pend_q <= pulse_req;
            end
            fig_q <= fig_d;
            sel_q <= 9'd1 << fig_d;
        end
    end

    assign fig_index        = fig_q;
    assign circle_select    = sel_q[0];
    assign square_select    = sel_q[1];
    assign triangle_select  = sel_q[2];
    assign oval_select      = sel_q[3];
    assign rectangle_select = sel_q[4];
    assign diamond_select   = sel_q[5];
    assign hexagon_select   = sel_q[6];
    assign pentagon_select  = sel_q[7];
    assign star_select      = sel_q[8];

endmodule

// File: tb/tb_figure_selector.sv
// Testbench for figure_selector with a short debounce window and a frame
// every 50 cycles. A cycle-level reference model written from the button
// rules (delay, stable-run length, wrap modulo 9) is compared every cycle.
module tb_figure_selector;

    localparam int DEB   = 4;
    localparam int FRAME = 50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] fig_index;
    logic       circle_select, square_select, triangle_select, oval_select;
    logic       rectangle_select, diamond_select, hexagon_select;
    logic       pentagon_select, star_select;
    logic [8:0] sel;

    int tests = 0;
    int fails = 0;
    int fcnt  = 0;

    // Reference model state: raw history, debounced level, run of mismatches.
    int m_idx;
    int m_pend;
    int m_h1 [2];
    int m_h2 [2];
    int m_deb [2];
    int m_debp [2];
    int m_run [2];

    figure_selector #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .btn_next         (btn_next),
        .btn_prev         (btn_prev),
        .frame_start      (frame_start),
        .fig_index        (fig_index),
        .circle_select    (circle_select),
        .square_select    (square_select),
        .triangle_select  (triangle_select),
        .oval_select      (oval_select),
        .rectangle_select (rectangle_select),
        .diamond_select   (diamond_select),
        .hexagon_select   (hexagon_select),
        .pentagon_select  (pentagon_select),
        .star_select      (star_select)
    );

    assign sel = {star_select, pentagon_select, hexagon_select, diamond_select,
                  rectangle_select, oval_select, triangle_select, square_select,
                  circle_select};

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_idx  = 0;
        m_pend = 0;
        for (int i = 0; i < 2; i++) begin
            m_h1[i] = 0; m_h2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_run[i] = 0;
        end
    endtask

    // Effect of one clock edge given the current inputs; requests are +1/-1/0.
    task automatic model_step();
        int  btn [2];
        bit  pn, pp;
        int  preq;
        btn[0] = int'(btn_next);
        btn[1] = int'(btn_prev);
        pn   = (m_deb[0] == 1) && (m_debp[0] == 0);
        pp   = (m_deb[1] == 1) && (m_debp[1] == 0);
        preq = (pn ? 1 : 0) - (pp ? 1 : 0);
        if (frame_start) begin
            m_idx  = (m_idx + ((pn || pp) ? preq : m_pend) + 9) % 9;
            m_pend = 0;
        end else if (pn || pp) begin
            m_pend = preq;
        end
        for (int i = 0; i < 2; i++) begin
            m_debp[i] = m_deb[i];
            if (m_h2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_h2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_h2[i] = m_h1[i];
            m_h1[i] = btn[i];
        end
    endtask

    // One clock: model the coming edge, then compare at the falling edge.
    task automatic tick();
        if (reset_n) model_step();
        @(posedge clk);
        @(negedge clk);
        if (reset_n) begin
            check("fig_index", int'(fig_index), m_idx);
            check("selects", int'(sel), 1 << m_idx);
            check("onehot", $countones(sel), 1);
        end
        fcnt        = (fcnt + 1) % FRAME;
        frame_start = (fcnt == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next edge will carry frame_start (always < FRAME ticks).
    task automatic wait_fs();
        int guard;
        guard = 0;
        while (!frame_start && guard < FRAME + 5) begin
            tick();
            guard++;
        end
        if (!frame_start) check("wait_fs_timeout", 0, 1);
    endtask

    task automatic set_btns(input int which, input logic v);
        if (which == 0 || which == 2) btn_next = v;
        if (which == 1 || which == 2) btn_prev = v;
    endtask

    task automatic press(input int which, input int hold);
        set_btns(which, 1'b1);
        ticks(hold);
        set_btns(which, 1'b0);
        ticks(DEB + 4);
    endtask

    // One press early in a frame, then run through the following commit edge.
    task automatic step_frame(input int which);
        wait_fs();
        press(which, 10);
        wait_fs();
        tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        ticks(3);
        reset_n = 1'b1;
        check("rst_fig", int'(fig_index), 0);
        check("rst_circle", int'(circle_select), 1);
        check("rst_sel", int'(sel), 1);
    endtask

    initial begin
        int which, hold, gap, guard;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single press held across a frame boundary: exactly one step.
        wait_fs();
        btn_next = 1'b1;
        ticks(60);
        btn_next = 1'b0;
        ticks(DEB + 4);
        wait_fs();
        tick();
        check("single_fig", int'(fig_index), 1);
        check("single_square", int'(square_select), 1);

        // Reset with a request pending discards it.
        wait_fs();
        btn_next = 1'b1;
        ticks(10);
        btn_next = 1'b0;
        do_reset();
        wait_fs();
        tick();
        check("post_rst_fig", int'(fig_index), 0);

        // Nine next presses wrap back to circle, then prev wraps to star.
        for (int i = 0; i < 9; i++) begin
            step_frame(0);
            check("wrap_fig", int'(fig_index), (i + 1) % 9);
            check("wrap_star", int'(star_select), (i == 7) ? 1 : 0);
        end
        check("wrap_circle", int'(circle_select), 1);
        step_frame(1);
        check("prev_wrap_fig", int'(fig_index), 8);
        check("prev_wrap_star", int'(star_select), 1);

        // Bounce shorter than the debounce window is rejected.
        wait_fs();
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1; ticks(3);
            btn_next = 1'b0; ticks(3);
        end
        ticks(DEB + 4);
        wait_fs();
        tick();
        check("bounce_fig", int'(fig_index), 8);
        step_frame(0);
        check("clean_after_bounce", int'(fig_index), 0);

        // Both buttons together cancel.
        step_frame(2);
        check("both_fig", int'(fig_index), 0);

        // Next then prev in one frame: the later request wins.
        for (int i = 0; i < 3; i++) step_frame(0);
        check("reach3", int'(fig_index), 3);
        wait_fs();
        press(0, 10);
        press(1, 10);
        wait_fs();
        tick();
        check("overwrite_fig", int'(fig_index), 2);

        // Press pulse lands exactly on the frame_start edge (7th edge after press).
        guard = 0;
        while (fcnt != FRAME - 6 && guard < FRAME + 5) begin
            tick();
            guard++;
        end
        btn_next = 1'b1;
        ticks(6);
        check("coincide_before", int'(fig_index), 2);
        tick();
        check("coincide_fig", int'(fig_index), 3);
        ticks(3);
        btn_next = 1'b0;
        ticks(DEB + 4);

        // Random presses, holds and gaps against the model.
        for (int n = 0; n < 150; n++) begin
            which = int'($urandom_range(0, 3));
            hold  = int'($urandom_range(1, 12));
            gap   = int'($urandom_range(0, 30));
            if (which < 3) set_btns(which, 1'b1);
            ticks(hold);
            btn_next = 1'b0;
            btn_prev = 1'b0;
            ticks(gap);
        end
        ticks(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
